hough_list_ctrl: RTL and testbench
==================================

HOUGH_LIST_CTRL -- requirements
Module: hough_list_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_SIZE, 8, node-SRAM address width; BIN_BITS, 4, bin index width; PAYLOAD_WIDTH, 24, node payload width.
REQ-002 SHALL have ports (name direction width meaning), clock and reset first:
- clk in 1: single clock, all logic on posedge.
- rst in 1: asynchronous, active-high reset.
- clr in 1: synchronous list clear, honoured in IDLE only.
- in_valid in 1 / in_ready out 1: insert handshake.
- in_bin in BIN_BITS / in_payload in PAYLOAD_WIDTH: insert target bin and data.
- q_valid in 1 / q_ready out 1: query handshake.
- q_bin in BIN_BITS: bin to traverse.
- out_valid out 1 / out_ready in 1: traversal output handshake.
- out_payload out PAYLOAD_WIDTH / out_last out 1 / out_nil out 1: node data, last node, empty bin.
- full out 1: no free node left.
- sram_we out 1 / sram_addr out ADDR_SIZE: node SRAM write enable and address.
- sram_wdata out ADDR_SIZE+PAYLOAD_WIDTH / sram_rdata in ADDR_SIZE+PAYLOAD_WIDTH: node word {next, payload}.

Function
REQ-003 SHALL store per-bin singly linked lists in the external node SRAM (1-cycle registered read; read output updates only while sram_we=0).
REQ-004 SHALL treat address 0 as NIL; allocatable nodes are 1..2^ADDR_SIZE-1.
REQ-005 SHALL hold a 2^BIN_BITS head table in registers plus a free pointer; allocation is bump-only, with no per-node free.
REQ-006 SHALL use states IDLE, FETCH, EMIT, EMPTY.
REQ-007 SHALL drive in_ready = (state==IDLE) && !full && !clr.
REQ-008 SHALL complete an insert in the handshake cycle: sram_we=1, sram_addr=free_ptr, sram_wdata={head[in_bin], in_payload}; head[in_bin]<=free_ptr; free_ptr<=free_ptr+1. Throughput is 1 insert/cycle, and new nodes are prepended (LIFO order).
REQ-009 SHALL assert full when free_ptr wraps to 0, i.e. after 2^ADDR_SIZE-1 inserts; full stays set until clr or rst.
REQ-010 SHALL drive q_ready = (state==IDLE) && !in_valid && !clr, so insert has priority over query.
REQ-011 On query handshake: ptr<=head[q_bin]; go to EMPTY if NIL, else FETCH.
REQ-012 EMPTY: out_valid=1, out_nil=1, out_last=1, out_payload=0; on out_ready go to IDLE.
REQ-013 FETCH: sram_we=0, sram_addr=ptr, out_valid=0; next state EMIT.
REQ-014 EMIT: sram_addr held at ptr; out_valid=1, out_payload=sram_rdata payload, out_last=(sram_rdata next==NIL), out_nil=0.
REQ-015 On EMIT handshake: go to IDLE if out_last, else ptr<=next and go to FETCH. Rate is 1 node per 2 cycles minimum.
REQ-016 Outputs SHALL stay stable while out_valid && !out_ready.
REQ-017 clr in IDLE SHALL set all heads to NIL and free_ptr to 1 and clear full in one cycle; clr in other states is ignored.
REQ-018 sram_we SHALL be 0 in every state other than an IDLE insert handshake.

Reset
REQ-019 rst SHALL force: state IDLE, all heads NIL, free_ptr 1, full 0, out_valid 0, out_last 0, out_nil 0, out_payload 0, sram_we 0, sram_addr 0.
REQ-020 rst mid-traversal SHALL abort the traversal, with out_valid low from the reset edge; SRAM contents are not cleared.

Configuration
REQ-021 With HOUGH_LIST_COUNT_EN defined: a per-bin node counter of ADDR_SIZE bits SHALL increment on insert and clear on clr/rst, and a port out_count (out, ADDR_SIZE) SHALL present the queried bin's count on every out_valid beat.
REQ-022 Without HOUGH_LIST_COUNT_EN: no counters and no out_count port.

Structure
REQ-023 A shared package SHALL hold the state enum, the NIL constant, and the node-word field offsets.
REQ-024 The block SHALL have no sub-module; the node SRAM is instantiated beside it by the parent, with DATA_WIDTH=ADDR_SIZE+PAYLOAD_WIDTH.

Verification
REQ-025 Insert payloads 0x11, 0x22, 0x33 to bin 5, then query bin 5 -> beats 0x33, 0x22, 0x11, last only on 0x11, nodes at addresses 3, 2, 1.
REQ-026 Query bin 7 with no inserts -> one beat with out_nil=1 and out_last=1, back to IDLE next cycle.
REQ-027 With ADDR_SIZE=3, insert 7 nodes -> full=1 and in_ready=0; the 8th insert is stalled; clr -> full=0 and a query returns nil.
REQ-028 Hold out_ready=0 for 5 cycles in EMIT -> out_payload and out_last remain stable and sram_we=0 throughout.
REQ-029 Assert in_valid and q_valid together -> insert accepted and q_ready=0 that cycle; query accepted the first cycle in_valid drops.
REQ-030 Pulse rst during the 2nd node of a 3-node traversal -> out_valid=0 immediately, and a subsequent query returns nil; with HOUGH_LIST_COUNT_EN, out_count=3 on each beat before the reset.

Source files
------------

// File: rtl/hough_list_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hough_list_pkg
// Brief    : Shared types/constants for the Hough bin linked-list controller.
// Revision : 1.0 - initial release
// ============================================================================
package hough_list_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EMIT  = 2'd2,
        ST_EMPTY = 2'd3
    } state_t;

    localparam int c_nil_addr    = 0;
    localparam int c_payload_lsb = 0;

    // Node word is {next, payload}: the next pointer sits directly above the payload.
    function automatic int next_field_lsb(input int payload_width);
        return c_payload_lsb + payload_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hough_list_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hough_list_ctrl
// Brief    : Per-bin LIFO linked lists in an external node SRAM with bump
//            allocation and a query/traversal stream. Optional per-bin node
//            counters and out_count port under `HOUGH_LIST_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hough_list_ctrl
    import hough_list_pkg::*;
#(
    parameter int ADDR_SIZE     = 8,
    parameter int BIN_BITS      = 4,
    parameter int PAYLOAD_WIDTH = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_BITS-1:0]           in_bin,
    input  logic [PAYLOAD_WIDTH-1:0]      in_payload,
    input  logic                          q_valid,
    output logic                          q_ready,
    input  logic [BIN_BITS-1:0]           q_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PAYLOAD_WIDTH-1:0]      out_payload,
    output logic                          out_last,
    output logic                          out_nil,
`ifdef HOUGH_LIST_COUNT_EN
    output logic [ADDR_SIZE-1:0]          out_count,
`endif
    output logic                          full,
    output logic                          sram_we,
    output logic [ADDR_SIZE-1:0]          sram_addr,
    output logic [ADDR_SIZE+PAYLOAD_WIDTH-1:0] sram_wdata,
    input  logic [ADDR_SIZE+PAYLOAD_WIDTH-1:0] sram_rdata
);

    localparam int                   c_num_bins = 2**BIN_BITS;
    localparam int                   c_next_lsb = next_field_lsb(PAYLOAD_WIDTH);
    localparam logic [ADDR_SIZE-1:0] c_nil      = ADDR_SIZE'(c_nil_addr);
    localparam logic [ADDR_SIZE-1:0] c_one      = ADDR_SIZE'(1);

    state_t               r_state;
    state_t               w_next_state;
    logic [ADDR_SIZE-1:0] r_head [c_num_bins];
    logic [ADDR_SIZE-1:0] r_free_ptr;
    logic [ADDR_SIZE-1:0] r_ptr;
    logic                 r_full;

    logic                     w_ins;
    logic                     w_qry;
    logic                     w_clr_now;
    logic [ADDR_SIZE-1:0]     w_rd_next;
    logic [PAYLOAD_WIDTH-1:0] w_rd_payload;

    assign in_ready     = (r_state == ST_IDLE) && !r_full && !clr;
    assign q_ready      = (r_state == ST_IDLE) && !in_valid && !clr;
    assign full         = r_full;
    assign w_ins        = in_valid && in_ready;
    assign w_qry        = q_valid && q_ready;
    assign w_clr_now    = (r_state == ST_IDLE) && clr;
    assign w_rd_next    = sram_rdata[c_next_lsb +: ADDR_SIZE];
    assign w_rd_payload = sram_rdata[c_payload_lsb +: PAYLOAD_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_qry) begin
                    w_next_state = (r_head[q_bin] == c_nil) ? ST_EMPTY : ST_FETCH;
                end
            end
            ST_FETCH: w_next_state = ST_EMIT;
            ST_EMIT: begin
                if (out_ready) begin
                    w_next_state = (w_rd_next == c_nil) ? ST_IDLE : ST_FETCH;
                end
            end
            ST_EMPTY: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // EMIT keeps the address on ptr so the registered read data stays put while stalled.
    always_comb begin
        out_valid   = 1'b0;
        out_payload = '0;
        out_last    = 1'b0;
        out_nil     = 1'b0;
        sram_we     = 1'b0;
        sram_addr   = '0;
        sram_wdata  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_ins) begin
                    sram_we                                  = 1'b1;
                    sram_addr                                = r_free_ptr;
                    sram_wdata[c_next_lsb +: ADDR_SIZE]      = r_head[in_bin];
                    sram_wdata[c_payload_lsb +: PAYLOAD_WIDTH] = in_payload;
                end
            end
            ST_FETCH: sram_addr = r_ptr;
            ST_EMIT: begin
                sram_addr   = r_ptr;
                out_valid   = 1'b1;
                out_payload = w_rd_payload;
                out_last    = (w_rd_next == c_nil);
            end
            ST_EMPTY: begin
                out_valid = 1'b1;
                out_nil   = 1'b1;
                out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_num_bins; i++) begin
                r_head[i] <= c_nil;
            end
            r_free_ptr <= c_one;
            r_full     <= 1'b0;
            r_ptr      <= c_nil;
        end else begin
            if (w_clr_now) begin
                for (int i = 0; i < c_num_bins; i++) begin
                    r_head[i] <= c_nil;
                end
                r_free_ptr <= c_one;
                r_full     <= 1'b0;
            end else if (w_ins) begin
                r_head[in_bin] <= r_free_ptr;
                r_free_ptr     <= r_free_ptr + c_one;
                // Last allocatable node taken: the pointer wraps onto NIL.
                if (r_free_ptr == {ADDR_SIZE{1'b1}}) begin
                    r_full <= 1'b1;
                end
            end else if (w_qry) begin
                r_ptr <= r_head[q_bin];
            end
            if ((r_state == ST_EMIT) && out_ready && (w_rd_next != c_nil)) begin
                r_ptr <= w_rd_next;
            end
        end
    end

`ifdef HOUGH_LIST_COUNT_EN
    logic [ADDR_SIZE-1:0] r_count [c_num_bins];
    logic [BIN_BITS-1:0]  r_q_bin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_num_bins; i++) begin
                r_count[i] <= '0;
            end
            r_q_bin <= '0;
        end else begin
            if (w_clr_now) begin
                for (int i = 0; i < c_num_bins; i++) begin
                    r_count[i] <= '0;
                end
            end else if (w_ins) begin
                r_count[in_bin] <= r_count[in_bin] + c_one;
            end else if (w_qry) begin
                r_q_bin <= q_bin;
            end
        end
    end

    assign out_count = out_valid ? r_count[r_q_bin] : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hough_list_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hough_list_ctrl
// Brief    : Randomized + directed bench for hough_list_ctrl with a queue-based
//            list model and a behavioural node SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hough_list_ctrl;

    localparam int A   = 3;
    localparam int B   = 4;
    localparam int P   = 24;
    localparam int W   = A + P;
    localparam int CAP = (1 << A) - 1;

    typedef struct {
        int           addr;
        logic [P-1:0] payload;
    } node_t;

    logic         clk = 1'b0;
    logic         rst, clr;
    logic         in_valid, in_ready;
    logic [B-1:0] in_bin;
    logic [P-1:0] in_payload;
    logic         q_valid, q_ready;
    logic [B-1:0] q_bin;
    logic         out_valid, out_ready;
    logic [P-1:0] out_payload;
    logic         out_last, out_nil, full;
    logic         sram_we;
    logic [A-1:0] sram_addr;
    logic [W-1:0] sram_wdata, sram_rdata;
`ifdef HOUGH_LIST_COUNT_EN
    logic [A-1:0] out_count;
`endif

    always #5 clk = ~clk;

    hough_list_ctrl #(.ADDR_SIZE(A), .BIN_BITS(B), .PAYLOAD_WIDTH(P)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin), .in_payload(in_payload),
        .q_valid(q_valid), .q_ready(q_ready), .q_bin(q_bin),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .out_last(out_last), .out_nil(out_nil),
`ifdef HOUGH_LIST_COUNT_EN
        .out_count(out_count),
`endif
        .full(full), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Node SRAM: registered read that holds while a write is in progress.
    logic [W-1:0] mem [1 << A];
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_wdata;
        else         sram_rdata     <= mem[sram_addr];
    end

    int    n_checks = 0;
    int    n_errors = 0;
    node_t lists [1 << B][$];
    int    used;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < (1 << B); i++) lists[i].delete();
        used = 0;
    endfunction

    function automatic logic [A-1:0] model_head(input int bin);
        return (lists[bin].size() > 0) ? A'(lists[bin][0].addr) : '0;
    endfunction

    function automatic void model_insert(input int bin, input logic [P-1:0] pl);
        node_t n;
        used++;
        n.addr    = used;
        n.payload = pl;
        lists[bin].push_front(n);
    endfunction

    task automatic do_insert(input int bin, input logic [P-1:0] pl);
        @(negedge clk);
        in_valid = 1'b1; in_bin = B'(bin); in_payload = pl; q_valid = 1'b0;
        #1;
        if (used == CAP) begin
            for (int i = 0; i < 3; i++) begin
                check_eq("stall_in_ready", in_ready, 0);
                check_eq("stall_we", sram_we, 0);
                check_eq("stall_full", full, 1);
                @(negedge clk); #1;
            end
            in_valid = 1'b0;
            return;
        end
        check_eq("ins_ready", in_ready, 1);
        check_eq("ins_we", sram_we, 1);
        check_eq("ins_addr", sram_addr, used + 1);
        check_eq("ins_wdata", sram_wdata, {model_head(bin), pl});
        @(posedge clk);
        model_insert(bin, pl);
        #1;
        in_valid = 1'b0;
        check_eq("full_after_ins", full, used == CAP);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b0; q_valid = 1'b0;
        #1;
        check_eq("clr_in_ready", in_ready, 0);
        check_eq("clr_q_ready", q_ready, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_clear();
        check_eq("clr_full", full, 0);
    endtask

    task automatic run_query(input int bin, input int smin, input int smax, input int abort_beat,
                             input bit collide, input int ibin, input logic [P-1:0] ipl);
        node_t        exp[$];
        int           n, beats, waited, stall;
        logic [P-1:0] hold_pl;
        logic         hold_last;
        @(negedge clk);
        out_ready = 1'b0; q_valid = 1'b1; q_bin = B'(bin);
        if (collide) begin
            in_valid = 1'b1; in_bin = B'(ibin); in_payload = ipl;
            #1;
            check_eq("col_in_ready", in_ready, 1);
            check_eq("col_we", sram_we, 1);
            check_eq("col_q_ready", q_ready, 0);
            @(posedge clk);
            model_insert(ibin, ipl);
            #1;
            in_valid = 1'b0;
        end
        #1;
        check_eq("q_ready", q_ready, 1);
        exp   = lists[bin];
        n     = exp.size();
        beats = (n == 0) ? 1 : n;
        @(posedge clk);
        #1;
        q_valid = 1'b0;
        for (int b = 0; b < beats; b++) begin
            waited = 0;
            while (!out_valid && waited < 6) begin
                if (n > 0) check_eq("fetch_addr", sram_addr, exp[b].addr);
                @(negedge clk); #1;
                waited++;
            end
            if (!out_valid) begin
                check_eq("beat_timeout", 0, 1);
                return;
            end
            check_eq("beat_nil", out_nil, n == 0);
            check_eq("beat_last", out_last, b == beats - 1);
            check_eq("beat_payload", out_payload, (n == 0) ? '0 : exp[b].payload);
            check_eq("beat_we", sram_we, 0);
            if (n > 0) check_eq("emit_addr", sram_addr, exp[b].addr);
`ifdef HOUGH_LIST_COUNT_EN
            check_eq("beat_count", out_count, n);
`endif
            if (b == abort_beat) begin
                rst = 1'b1;
                #1;
                check_eq("abort_valid", out_valid, 0);
                check_eq("abort_full", full, 0);
                @(negedge clk);
                rst = 1'b0;
                model_clear();
                return;
            end
            hold_pl   = out_payload;
            hold_last = out_last;
            stall     = $urandom_range(smin, smax);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk); #1;
                check_eq("stall_valid", out_valid, 1);
                check_eq("stall_payload", out_payload, hold_pl);
                check_eq("stall_last", out_last, hold_last);
                check_eq("stall_sram_we", sram_we, 0);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        check_eq("post_valid", out_valid, 0);
        check_eq("post_q_ready", q_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_bin = '0; in_payload = '0;
        q_valid = 1'b0; q_bin = '0; out_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_out_nil", out_nil, 0);
        check_eq("rst_out_payload", out_payload, 0);
        check_eq("rst_sram_we", sram_we, 0);
        check_eq("rst_sram_addr", sram_addr, 0);
        check_eq("rst_full", full, 0);
        rst = 1'b0;

        run_query(7, 0, 0, -1, 1'b0, 0, '0);

        do_insert(5, 24'h11);
        do_insert(5, 24'h22);
        do_insert(5, 24'h33);
        run_query(5, 0, 0, -1, 1'b0, 0, '0);
        run_query(5, 5, 5, -1, 1'b0, 0, '0);

        for (int i = 0; i < 4; i++) do_insert(1, P'($urandom));
        check_eq("cap_full", full, 1);
        do_insert(2, 24'hABCDEF);
        do_clr();
        run_query(5, 0, 0, -1, 1'b0, 0, '0);

        run_query(3, 0, 1, -1, 1'b1, 3, 24'h5A5A5A);

        do_clr();
        for (int i = 0; i < 3; i++) do_insert(2, P'($urandom));
        run_query(2, 0, 1, 1, 1'b0, 0, '0);
        run_query(2, 0, 0, -1, 1'b0, 0, '0);

        for (int it = 0; it < 250; it++) begin
            int op;
            int bn;
            op = $urandom_range(0, 9);
            bn = $urandom_range(0, 3);
            if (op < 6)      do_insert(bn, P'($urandom));
            else if (op < 9) run_query(bn, 0, 2, -1, (op == 8) && (used < CAP),
                                       $urandom_range(0, 3), P'($urandom));
            else             do_clr();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
